// File: rtl/replay_ctrl.sv
// Replay buffer controller: sequence assignment, ACK purge, NAK/timeout replay and
// replay-count rollover for a data-link-layer transmit path.
module replay_ctrl #(
  parameter int unsigned SEQ_W      = 12,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned TIMER_W    = 10,
  parameter int unsigned TIMEOUT    = 600,
  parameter int unsigned MAX_REPLAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tlp_valid,
  output logic              tlp_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SEQ_W-1:0]  tlp_seq,
  input  logic              acknak_valid,
  input  logic [1:0]        acknak,
  input  logic [SEQ_W-1:0]  acknak_seq,
  output logic              rep_valid,
  input  logic              rep_ready,
  output logic [ADDR_W-1:0] rep_addr,
  output logic [SEQ_W-1:0]  rep_seq,
  output logic [ADDR_W:0]   occupancy,
  output logic              timeout_o,
  output logic              rollover_o,
  output logic              dllp_err
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  localparam logic [SEQ_W-1:0] SeqOne   = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] DepthSeq = SEQ_W'(DEPTH);

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   next_seq_q, next_seq_d;
  logic [SEQ_W-1:0]   acked_seq_q, acked_seq_d;
  logic [SEQ_W-1:0]   rep_ptr_q, rep_ptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         replay_num_q, replay_num_d;

  logic [SEQ_W-1:0] occ_full, seq_off, last_seq;
  logic             is_ack, is_nak, seq_ok, purge, progress, window_left, expire;
  logic [3:0]       num_base, num_inc;

  assign occ_full  = next_seq_q - acked_seq_q - SeqOne;
  assign last_seq  = next_seq_q - SeqOne;
  assign seq_off   = acknak_seq - acked_seq_q;
  assign is_ack    = acknak_valid && (acknak == 2'b01);
  assign is_nak    = acknak_valid && (acknak == 2'b10);
  assign seq_ok    = (seq_off <= occ_full);
  assign purge     = (is_ack || is_nak) && seq_ok;
  assign dllp_err  = (is_ack || is_nak) && !seq_ok;
  assign progress  = purge && (acknak_seq != acked_seq_q);

  assign acked_seq_d = purge ? acknak_seq : acked_seq_q;
  // Anything still unacknowledged (writes landing this cycle are not replayed yet).
  assign window_left = (acked_seq_d != last_seq);

  assign occupancy = occ_full[ADDR_W:0];
  assign tlp_ready = (state_q == StIdle) && (occ_full < DepthSeq);
  assign wr_en     = tlp_valid && tlp_ready;
  assign wr_addr   = next_seq_q[ADDR_W-1:0];
  assign tlp_seq   = next_seq_q;

  assign expire    = (state_q == StIdle) && (occ_full != '0) &&
                     (timer_q == TIMER_W'(TIMEOUT - 1));
  assign timeout_o = expire;

  assign num_base = progress ? 4'd0 : {1'b0, replay_num_q};
  assign num_inc  = num_base + 4'd1;

  assign rep_addr = rep_valid ? rep_ptr_q[ADDR_W-1:0] : '0;
  assign rep_seq  = rep_valid ? rep_ptr_q : '0;

  always_comb begin
    state_d      = state_q;
    next_seq_d   = wr_en ? next_seq_q + SeqOne : next_seq_q;
    rep_ptr_d    = rep_ptr_q;
    timer_d      = timer_q;
    replay_num_d = num_base[2:0];
    rep_valid    = 1'b0;
    rollover_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // NAK and expiry on the same cycle collapse into a single replay start.
        if (((is_nak && purge) || expire) && window_left) begin
          state_d   = StReplay;
          rep_ptr_d = acked_seq_d + SeqOne;
          timer_d   = '0;
          if (num_inc == 4'(MAX_REPLAY)) begin
            rollover_o   = 1'b1;
            replay_num_d = 3'd0;
          end else begin
            replay_num_d = num_inc[2:0];
          end
        end else if (expire || progress || (occ_full == '0)) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      StReplay: begin
        rep_valid = 1'b1;
        timer_d   = '0;
        if (purge && (seq_off >= (rep_ptr_q - acked_seq_q))) begin
          rep_ptr_d = acked_seq_d + SeqOne;
          if (!window_left) state_d = StIdle;
        end else if (rep_ready) begin
          rep_ptr_d = rep_ptr_q + SeqOne;
          if (rep_ptr_q == last_seq) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      next_seq_q   <= '0;
      acked_seq_q  <= '1;
      rep_ptr_q    <= '0;
      timer_q      <= '0;
      replay_num_q <= '0;
    end else begin
      state_q      <= state_d;
      next_seq_q   <= next_seq_d;
      acked_seq_q  <= acked_seq_d;
      rep_ptr_q    <= rep_ptr_d;
      timer_q      <= timer_d;
      replay_num_q <= replay_num_d;
    end
  end

endmodule

// File: doc/replay_ctrl.md
# replay_ctrl

Parametrised data-link-layer replay buffer controller. It assigns sequence numbers to outgoing TLPs and generates write addresses into an external replay RAM. It purges entries on ACK, replays unacknowledged entries on NAK or replay-timer expiry, and counts replay attempts with rollover detection. It sits between the transaction-layer TLP source and the replay RAM / link transmit mux, and replaces the fixed-width single-mode replay FSM.

## Interface
- SEQ_W, 12, sequence number width (modulo 2^SEQ_W arithmetic)
- ADDR_W, 4, replay RAM address width; DEPTH = 2^ADDR_W TLP entries; ADDR_W < SEQ_W
- TIMER_W, 10, replay timer width
- TIMEOUT, 600, replay timer expiry count in cycles; 1 ≤ TIMEOUT < 2^TIMER_W
- MAX_REPLAY, 4, replays allowed before rollover; 1 ≤ MAX_REPLAY ≤ 8
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tlp_valid  in  1  source has a new TLP to store/send
- tlp_ready  out  1  controller accepts the TLP this cycle
- wr_en  out  1  write strobe to replay RAM (= tlp_valid & tlp_ready)
- wr_addr  out  ADDR_W  replay RAM write address (next_seq[ADDR_W-1:0])
- tlp_seq  out  SEQ_W  sequence number assigned to the accepted TLP
- acknak_valid  in  1  received ACK/NAK DLLP this cycle
- acknak  in  2  2'b01 ACK, 2'b10 NAK; other codes ignored
- acknak_seq  in  SEQ_W  AckNak_Seq_Num of the DLLP
- rep_valid  out  1  replay entry presented to transmit mux
- rep_ready  in  1  transmit mux accepts replay entry (not busy)
- rep_addr  out  ADDR_W  replay RAM read address
- rep_seq  out  SEQ_W  sequence number of the presented replay entry
- occupancy  out  ADDR_W+1  number of unacknowledged TLPs
- timeout_o  out  1  one-cycle pulse on replay timer expiry
- rollover_o  out  1  one-cycle pulse when the replay count reaches MAX_REPLAY
- dllp_err  out  1  one-cycle pulse on an ACK/NAK whose seq is outside the outstanding window

## Operation
- State: next_seq, acked_seq, rep_ptr (SEQ_W each), timer (TIMER_W), replay_num (3 bits), FSM {IDLE, REPLAY}.
- Reset: next_seq=0, acked_seq=all ones, rep_ptr=0, timer=0, replay_num=0, state=IDLE. All outputs 0 except tlp_ready=1.
- occupancy = (next_seq − acked_seq − 1) mod 2^SEQ_W.
- A seq s is valid if (s − acked_seq) mod 2^SEQ_W ≤ occupancy.
- tlp_ready = (state==IDLE) & (occupancy < DEPTH). Each accept increments next_seq with wrap.
- ACK, valid s: acked_seq←s. If s≠acked_seq (forward progress): timer←0 and replay_num←0. Allowed in either state.
- NAK, valid s: apply the ACK purge to s, then enter REPLAY with rep_ptr←s+1, replay_num+1. If nothing remains after the purge, stay in IDLE with no replay.
- NAK received in REPLAY: purge only; the replay in progress continues; no new replay is started.
- Invalid seq (either code): no state change; dllp_err pulses.
- Timer: increments each cycle while IDLE with occupancy>0. Holds at 0 while occupancy=0 or in REPLAY. On timer==TIMEOUT−1: timeout_o pulses, timer←0, rep_ptr←acked_seq+1, replay_num+1, enter REPLAY.
- Replay count: if the increment makes replay_num == MAX_REPLAY, rollover_o pulses, replay_num←0, and the replay still proceeds.
- REPLAY: rep_valid=1, rep_addr=rep_ptr[ADDR_W-1:0], rep_seq=rep_ptr. On rep_valid&rep_ready, rep_ptr increments.
- Exit REPLAY to IDLE after the transfer of entry next_seq−1, with timer←0.
- A purge during REPLAY that passes rep_ptr forces rep_ptr←acked_seq+1. If that empties the window, return to IDLE next cycle.
- Simultaneous events: an ACK/NAK on the same cycle as a write both apply. A NAK on the same cycle as a timer expiry starts one replay and increments replay_num once; timeout_o still pulses.

## Timing
- wr_en, wr_addr, tlp_seq are combinational from the current state; the next_seq update is visible one cycle later.
- ACK/NAK effect on occupancy and tlp_ready: one cycle latency.
- rep_valid rises the cycle after the NAK or expiry cycle; one entry per cycle while rep_ready=1; rep_ready low stalls with outputs held.
- Reset asserted mid-replay: next cycle matches the reset state; the replay is abandoned.

## Test plan
- Reset, then write 9 TLPs back-to-back → tlp_seq 0..8, wr_addr 0..8, occupancy=9, timer counting.
- ACK seq 4 → occupancy=4 next cycle, timer=0, replay_num=0; ACK seq 20 → dllp_err pulse, no change.
- NAK seq 4 with 0..8 outstanding, rep_ready toggled 1,0,1… → rep_seq 5..8 each held while stalled, return to IDLE after 8, tlp_ready low throughout.
- No ACK for TIMEOUT cycles with 3 outstanding → timeout_o; replay of all 3; after MAX_REPLAY=4 expiries rollover_o pulses and replay_num=0.
- Fill DEPTH=16 entries → tlp_ready=0; ACK seq 0 → exactly one more accept; next_seq wrapping 4095→0 keeps occupancy correct.
- ACK during replay past rep_ptr → rep_ptr jumps to acked_seq+1; reset mid-replay → rep_valid=0 next cycle.
